// File: rtl/fir_out_requant.sv
// FIR output requantiser: drops the filter start-up transient, decimates, rounds,
// saturates to OUT_WIDTH and buffers the results in a small valid/ready FIFO.
module fir_out_requant #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  parameter int WARMUP     = 49,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_en,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        sat_flag,
  output logic                        ovf_flag,
  input  logic                        flag_clr,
  output logic [15:0]                 drop_cnt
);

  localparam int WW = $clog2(WARMUP + 2);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = IN_WIDTH + 1 - SHIFT;
  localparam int XW = ((RW > OUT_WIDTH) ? RW : OUT_WIDTH) + 1;

  localparam logic signed [IN_WIDTH:0] HALF  = (IN_WIDTH + 1)'(1) <<< (SHIFT - 1);
  localparam logic signed [XW-1:0]     MAX_V = (XW'(1) <<< (OUT_WIDTH - 1)) - XW'(1);
  localparam logic signed [XW-1:0]     MIN_V = -(XW'(1) <<< (OUT_WIDTH - 1));
  localparam logic [OUT_WIDTH-1:0]     MAX_O = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0]     MIN_O = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  logic [WW-1:0] warm_cnt;
  logic [PW-1:0] phase;
  logic          warm_done;
  logic          keep;

  assign warm_done = (warm_cnt == WW'(WARMUP));
  assign keep      = in_en && warm_done && (phase == '0);

  // The warm-up counter freezes at WARMUP; only then does the decimation phase run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm_cnt <= '0;
      phase    <= '0;
    end else if (in_en) begin
      if (!warm_done)                    warm_cnt <= warm_cnt + 1'b1;
      else if (phase == PW'(DECIM - 1))  phase    <= '0;
      else                               phase    <= phase + 1'b1;
    end
  end

  // Stage 1: round half up; the extra MSB keeps the bias add from wrapping.
  logic signed [IN_WIDTH:0] rnd_sum;
  logic signed [IN_WIDTH:0] rnd_shift;
  logic                     s1_valid;
  logic signed [RW-1:0]     s1_data;

  assign rnd_sum   = $signed({in_data[IN_WIDTH-1], in_data}) + HALF;
  assign rnd_shift = rnd_sum >>> SHIFT;

  // NOTE: sequential state always uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= keep;
      if (keep) s1_data <= rnd_shift[RW-1:0];
    end
  end

  // Stage 2: saturate to the output range.
  logic signed [XW-1:0]        s1_ext;
  logic                        clip_hi;
  logic                        clip_lo;
  logic                        sat_set;
  logic [OUT_WIDTH-1:0]        sat_val;
  logic                        s2_valid;
  logic signed [OUT_WIDTH-1:0] s2_data;

  assign s1_ext  = XW'(s1_data);
  assign clip_hi = s1_ext > MAX_V;
  assign clip_lo = s1_ext < MIN_V;
  assign sat_set = s1_valid && (clip_hi || clip_lo);
  assign sat_val = clip_hi ? MAX_O : (clip_lo ? MIN_O : s1_ext[OUT_WIDTH-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= sat_val;
    end
  end

  // Output FIFO; a full FIFO still accepts a push when the head leaves the same cycle.
  logic signed [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [CW-1:0]               count;
  logic                        full;
  logic                        pop;
  logic                        push;
  logic                        drop;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = s2_valid && (!full || pop);
  assign drop      = s2_valid && full && !pop;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // NOTE: the storage array has no reset; the count alone defines which entries are
  // live, and out_data is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s2_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky status: a set event in the same cycle as flag_clr takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (sat_set)       sat_flag <= 1'b1;
      else if (flag_clr) sat_flag <= 1'b0;

      if (drop)          ovf_flag <= 1'b1;
      else if (flag_clr) ovf_flag <= 1'b0;

      if (drop) begin
        if (flag_clr)                drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (flag_clr) begin
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fir_out_requant.sv
// Bench for fir_out_requant: two instances (DECIM=1 and DECIM=3) share stimulus; a
// sample-level reference model feeds per-instance scoreboards drained by a monitor.
module tb_fir_out_requant;

  localparam int IW    = 32;
  localparam int OW    = 16;
  localparam int SH    = 15;
  localparam int WU    = 49;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_en = 1'b0;
  logic signed [IW-1:0] in_data = '0;
  logic                 out_ready = 1'b0;
  logic                 flag_clr = 1'b0;

  logic                 vld0, vld1, satf0, satf1, ovff0, ovff1;
  logic signed [OW-1:0] dat0, dat1;
  logic [15:0]          dcnt0, dcnt1;

  always #5 clk = ~clk;

  fir_out_requant #(.DECIM(1)) u_dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_data(in_data),
    .out_valid(vld0), .out_ready(out_ready), .out_data(dat0),
    .sat_flag(satf0), .ovf_flag(ovff0), .flag_clr(flag_clr), .drop_cnt(dcnt0)
  );

  fir_out_requant #(.DECIM(3)) u_dec (
    .clk(clk), .rst(rst), .in_en(in_en), .in_data(in_data),
    .out_valid(vld1), .out_ready(out_ready), .out_data(dat1),
    .sat_flag(satf1), .ovf_flag(ovff1), .flag_clr(flag_clr), .drop_cnt(dcnt1)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state, one slot per instance.
  int     q_idx;
  int     occ [2];
  bit     p0v [2];
  bit     p1v [2];
  longint p0  [2];
  longint p1  [2];
  bit     m_sat [2];
  bit     m_ovf [2];
  int     m_drop [2];
  int     n_out [2];
  longint exp_q0 [$];
  longint exp_q1 [$];
  bit     prev_stall [2];
  logic signed [OW-1:0] prev_d [2];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dec_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // floor((x + 2^(SH-1)) / 2^SH), done with integer division and an explicit floor fix.
  function automatic longint ref_round(input longint x);
    longint den, num, q;
    den = longint'(1) << SH;
    num = x + (den / 2);
    q   = num / den;
    if (num < 0 && q * den != num) q = q - 1;
    return q;
  endfunction

  function automatic bit is_clipped(input longint r);
    return (r > 32767) || (r < -32768);
  endfunction

  function automatic longint clip(input longint r);
    if (r > 32767)  return 32767;
    if (r < -32768) return -32768;
    return r;
  endfunction

  task automatic model_reset();
    q_idx = 0;
    for (int k = 0; k < 2; k++) begin
      occ[k] = 0; p0v[k] = 0; p1v[k] = 0; p0[k] = 0; p1[k] = 0;
      m_sat[k] = 0; m_ovf[k] = 0; m_drop[k] = 0; n_out[k] = 0;
      prev_stall[k] = 0; prev_d[k] = '0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // One clock edge of the model, using the inputs presented to that edge.
  task automatic model_edge();
    longint r;
    bit     pop, drop, kept;
    r = ref_round(longint'(in_data));
    for (int k = 0; k < 2; k++) begin
      pop  = (occ[k] > 0) && out_ready;
      drop = 0;
      if (p1v[k]) begin
        if (occ[k] < DEPTH || pop) begin
          occ[k]++;
          if (k == 0) exp_q0.push_back(clip(p1[k]));
          else        exp_q1.push_back(clip(p1[k]));
        end else begin
          drop = 1;
        end
      end
      if (pop) occ[k]--;
      if (p0v[k] && is_clipped(p0[k])) m_sat[k] = 1;
      else if (flag_clr)               m_sat[k] = 0;
      if (drop) begin
        m_ovf[k]  = 1;
        m_drop[k] = flag_clr ? 1 : ((m_drop[k] < 65535) ? m_drop[k] + 1 : 65535);
      end else if (flag_clr) begin
        m_ovf[k]  = 0;
        m_drop[k] = 0;
      end
      p1v[k] = p0v[k];
      p1[k]  = p0[k];
      kept   = in_en && (q_idx >= WU) && ((q_idx - WU) % dec_of(k) == 0);
      p0v[k] = kept;
      p0[k]  = r;
    end
    if (in_en) q_idx++;
  endtask

  // Monitor: compares the head of each instance's output against its scoreboard.
  task automatic mon(input int k, input logic v, input logic signed [OW-1:0] d);
    longint e;
    check(k == 0 ? "out_valid0" : "out_valid1", v, occ[k] > 0);
    if (prev_stall[k] && v)
      check(k == 0 ? "stall_stable0" : "stall_stable1", d, prev_d[k]);
    if (v && out_ready) begin
      if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
        check(k == 0 ? "extra_out0" : "extra_out1", v, 1'b0);
      end else begin
        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check(k == 0 ? "out_data0" : "out_data1", d, e);
        n_out[k]++;
      end
    end
    prev_stall[k] = v && !out_ready;
    prev_d[k]     = d;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      mon(0, vld0, dat0);
      mon(1, vld1, dat1);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_edge();
      #1;
    end
  endtask

  task automatic feed(input longint x);
    in_en   = 1'b1;
    in_data = x[IW-1:0];
    step();
    in_en   = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step(10);
  endtask

  task automatic pulse_clr();
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
  endtask

  task automatic check_flags();
    check("sat_flag0", satf0, m_sat[0]);
    check("sat_flag1", satf1, m_sat[1]);
    check("ovf_flag0", ovff0, m_ovf[0]);
    check("ovf_flag1", ovff1, m_ovf[1]);
    check("drop_cnt0", dcnt0, m_drop[0]);
    check("drop_cnt1", dcnt1, m_drop[1]);
  endtask

  initial begin
    model_reset();

    // Reset state
    step(3);
    check("rst_valid0", vld0, 1'b0);
    check("rst_data0", dat0, 0);
    check("rst_valid1", vld1, 1'b0);
    check_flags();
    rst = 1'b1;

    // Warm-up: first output three edges after qualified sample 49 enters
    out_ready = 1'b1;
    in_en     = 1'b1;
    in_data   = 32'sd3276800;
    for (int i = 0; i < 60; i++) begin
      step();
      if (i == 50) check("warm_early_valid", vld0, 1'b0);
      if (i == 51) begin
        check("warm_first_valid", vld0, 1'b1);
        check("warm_first_data", dat0, 100);
      end
    end
    in_en = 1'b0;
    drain();
    check("warm_count0", n_out[0], 11);
    check("warm_count1", n_out[1], 4);

    // Rounding ties and near-ties
    feed(16384);
    feed(-16384);
    feed(-16385);
    feed(49152);
    drain();
    check("round_no_sat", satf0, 1'b0);
    check_flags();

    // Saturation and sticky clear
    feed(64'sh7FFF_FFFF);
    feed(-64'sh8000_0000);
    drain();
    check("sat_set", satf0, 1'b1);
    check_flags();
    pulse_clr();
    check("sat_cleared", satf0, 1'b0);
    check_flags();

    // Back-pressure: FIFO keeps 1..4, drops three
    out_ready = 1'b0;
    for (int k = 1; k <= 7; k++) feed(longint'(k) * 32768);
    step(4);
    check("bp_valid", vld0, 1'b1);
    check("bp_ovf", ovff0, 1'b1);
    check("bp_drops", dcnt0, 3);
    check_flags();
    step(3);
    drain();
    pulse_clr();
    check_flags();

    // Full FIFO with a pop in the same cycle as the push: no drop
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) feed(longint'(k) * 65536);
    step(3);
    feed(5 * 65536);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step(2);
    check("full_pop_no_drop", dcnt0, 0);
    check_flags();
    drain();

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      in_en     = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      if ($urandom_range(0, 1) == 0) in_data = in_data >>> $urandom_range(8, 20);
      out_ready = ($urandom_range(0, 1) == 1);
      flag_clr  = ($urandom_range(0, 29) == 0);
      step();
      if (i % 50 == 49) check_flags();
    end
    in_en    = 1'b0;
    flag_clr = 1'b0;
    drain();
    check_flags();

    // Mid-stream reset with entries buffered
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) feed(longint'(k) * 32768);
    step(3);
    check("pre_rst_valid", vld0, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid0", vld0, 1'b0);
    check("mid_rst_valid1", vld1, 1'b0);
    check("mid_rst_data0", dat0, 0);
    model_reset();
    step(2);
    rst = 1'b1;

    // Warm-up again, then decimation pattern
    out_ready = 1'b1;
    for (int i = 0; i < WU; i++) feed(0);
    step(4);
    check("rewarm_valid", vld0, 1'b0);
    check("rewarm_count", n_out[0], 0);
    for (int k = 0; k < 12; k++) feed(longint'(k) * 32768);
    drain();
    check("decim_count1", n_out[1], 4);
    check("decim_count0", n_out[0], 12);
    check("q_empty0", exp_q0.size(), 0);
    check("q_empty1", exp_q1.size(), 0);
    check_flags();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
